// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready holding register
module uart_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rxs, rxs_prev;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_d;
  logic            valid_d, ferr_d, ovr_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxs_prev  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta   <= RXD;
      rxs       <= rx_meta;
      rxs_prev  <= rxs;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = rx_valid;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (rx_valid && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge-triggered so a line stuck low cannot start repeated frames.
        if (rxs_prev && !rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            // A same-cycle accept frees the slot, so the new byte replaces the old.
            if (!rx_valid || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       RXD = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .RXD      (RXD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pcnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int busy_cyc = 0;
  int drop_cnt = 0;
  logic valid_q = 1'b0;
  int rise_cyc[$];
  logic [7:0] rise_dat[$];

  always @(posedge clk) pcnt <= pcnt + 1;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (!rx_valid) drop_cnt <= drop_cnt + 1;
    if (rx_valid && !valid_q) begin
      rise_cyc.push_back(pcnt);
      rise_dat.push_back(rx_data);
    end
    valid_q <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RXD = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b, f0, o0, bz0, d0, start_p, lat;
  logic [7:0] frame5a;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    idle(5);

    b = rise_cyc.size(); f0 = ferr_cnt; o0 = ovr_cnt; start_p = pcnt;
    send_frame(8'hA5, 1'b1);
    idle(5);
    check("basic_valid", rx_valid, 1'b1);
    check("basic_data", rx_data, 8'hA5);
    check("basic_rise_count", rise_cyc.size() - b, 1);
    lat = (rise_cyc.size() > b) ? rise_cyc[b] - start_p : -1;
    check("basic_latency_96_98", (lat >= 96 && lat <= 98), 1'b1);
    check("basic_ferr", ferr_cnt - f0, 0);
    check("basic_ovr", ovr_cnt - o0, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check("accept_valid_clear", rx_valid, 1'b0);
    check("accept_data_hold", rx_data, 8'hA5);
    idle(5);

    rx_ready = 1'b1;
    b = rise_cyc.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(10);
    rx_ready = 1'b0;
    check("b2b_rise_count", rise_cyc.size() - b, 2);
    if (rise_cyc.size() >= b + 2) begin
      check("b2b_first", rise_dat[b], 8'h00);
      check("b2b_second", rise_dat[b+1], 8'hFF);
      check("b2b_spacing", rise_cyc[b+1] - rise_cyc[b], 100);
    end
    check("b2b_ferr", ferr_cnt - f0, 0);
    check("b2b_ovr", ovr_cnt - o0, 0);

    b = rise_cyc.size(); f0 = ferr_cnt; o0 = ovr_cnt; bz0 = busy_cyc;
    RXD = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    check("glitch_busy_cycles", busy_cyc - bz0, 5);
    check("glitch_busy_now", busy, 1'b0);
    check("glitch_no_valid", rise_cyc.size() - b, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_ovr", ovr_cnt - o0, 0);

    b = rise_cyc.size(); f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    bz0 = busy_cyc;
    repeat (40) @(posedge clk);
    #1;
    check("ferr_pulse_once", ferr_cnt - f0, 1);
    check("ferr_no_valid", rise_cyc.size() - b, 0);
    check("ferr_valid_low", rx_valid, 1'b0);
    check("ferr_low_no_retrigger", busy_cyc - bz0, 0);
    idle(20);

    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(10);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_pulse_once", ovr_cnt - o0, 1);

    o0 = ovr_cnt; d0 = drop_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    idle(5);
    check("simul_data", rx_data, 8'h22);
    check("simul_valid", rx_valid, 1'b1);
    check("simul_no_drop", drop_cnt - d0, 0);
    check("simul_no_ovr", ovr_cnt - o0, 0);

    frame5a = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(frame5a[i]);
    RXD = frame5a[4];
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_ovr", overrun, 1'b0);
    check("midrst_busy", busy, 1'b0);
    RXD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(5);
    check("post_rst_data", rx_data, 8'h5A);
    check("post_rst_valid", rx_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable 8N1 UART receiver, the receive-side counterpart of the SOC's serial transmit path. It decodes a serial line, either the SOC's `TXD` looped into a bench or a host link into `RXD`, and presents each byte through a one-entry valid/ready holding register. It also flags framing errors and overruns. It is used inside the SOC for its `RXD` input and in benches as a `TXD` monitor.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
- `CLKS_PER_BIT` is derived as CLK_FREQ/BAUD_RATE (integer division). It must be ≥ 4; elaboration fails otherwise.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `RXD`  in  1: serial input, asynchronous to `clk`, idle high.
- `rx_data`  out  8: received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1: holding register full.
- `rx_ready`  in  1: consumer accepts the byte when `rx_valid` & `rx_ready`.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1: one-cycle pulse when a good byte is dropped because the holding register is full.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- **Synchronizer:** `RXD` passes through 2 flops that reset to 1. All decoding uses the synced bit `rxs`.
- **State machine:** IDLE, START, DATA, STOP. One counter, `cnt`, is ceil(log2(CLKS_PER_BIT)) bits wide. One bit index is 3 bits wide.
- **IDLE:** a falling edge of `rxs` (previous 1, current 0) moves to START with `cnt`=0. A line that stays low does not re-trigger.
- **START:** when `cnt` = CLKS_PER_BIT/2 − 1, sample `rxs`.
  - `rxs`=0: go to DATA with `cnt`=0 and index 0.
  - `rxs`=1: treat as a glitch and return to IDLE. No output changes.
- **DATA:** when `cnt` = CLKS_PER_BIT − 1, sample `rxs` into the shift register, LSB first, and reset `cnt`. After index 7, go to STOP.
- **STOP:** when `cnt` = CLKS_PER_BIT − 1, sample `rxs`, then go to IDLE in every case.
  - `rxs`=1 (good byte):
    - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
    - Otherwise: pulse `overrun`. The held byte and `rx_valid` are kept.
  - `rxs`=0: pulse `frame_err`. The byte is discarded and `rx_valid`/`rx_data` are untouched.
- **Handshake:** when `rx_valid` & `rx_ready` with no byte completing, `rx_valid` clears next cycle. `rx_data` holds its last value.
- **Simultaneous handshake and load:** the new byte replaces the old one, `rx_valid` stays 1, and there is no overrun.
- **`rx_ready` while `rx_valid`=0:** ignored.
- **Reset (asynchronous, any time, including mid-frame):**
  - state IDLE, `cnt`=0, shift register 0;
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0;
  - synchronizer flops = 1.
  - After release, a frame already in progress is not recovered. The first falling edge seen after release starts a new frame.

## Timing
- Let T0 be the cycle in which IDLE sees the `rxs` falling edge. This is 2–3 cycles after the `RXD` pin edge, depending on phase.
- START mid-bit sample: T0 + CLKS_PER_BIT/2.
- Data bit i sample: T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample: T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `rx_valid`, `frame_err` or `overrun` changes on the clock edge right after the stop sample. Every output is registered.
- `busy` rises at T0+1 and falls with the stop-sample exit.
- Back-to-back frames: a start bit that begins right after the stop bit is caught, because IDLE is re-entered about mid-stop-bit.
- Throughput is 1 byte per 10 bit times. A consumer must accept within 1 frame time to avoid overrun.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD_RATE=100_000, so CLKS_PER_BIT=10 and one bit lasts 10 `clk` periods.

- **Basic byte:** drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with `rx_ready`=0 → `rx_valid`=1 with `rx_data`=0xA5, 96–98 cycles after the start edge; `frame_err`/`overrun` stay 0. Then pulse `rx_ready` for 1 cycle → `rx_valid`=0 next cycle.
- **Back-to-back:** 0x00 then 0xFF with no idle gap, `rx_ready` tied 1 → two `rx_valid` cycles carrying 0x00 then 0xFF, 100 cycles apart; no errors.
- **Glitch:** `RXD` low for 3 cycles, then high → `busy` pulses, returns to IDLE; `rx_valid`, `frame_err` and `overrun` stay 0.
- **Framing error:** 0x3C with the stop bit held 0 → one-cycle `frame_err`; `rx_valid` stays 0. Holding `RXD` low afterwards causes no new frame until `RXD` returns high then falls.
- **Overrun and simultaneous accept:**
  - 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses once.
  - Repeat with `rx_ready`=1 exactly in the 0x22 load cycle → `rx_data`=0x22, `rx_valid` stays 1, no overrun.
- **Reset mid-frame:** assert `resetn`=0 during bit 4 of a frame, asynchronously between edges → all outputs 0 immediately. After release, the next full 0x5A frame → `rx_data`=0x5A.
